// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - frame-paced ball position/velocity engine with paddle, wall and loss handling
module ball_motion #(
  parameter int X_MIN = 0,
  parameter int X_MAX = 639,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 479,
  parameter int SIZE  = 4,
  parameter int STEP  = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       launch,
  input  logic [9:0] BarX,
  input  logic [9:0] BarY,
  input  logic [9:0] Bar_Sizex,
  input  logic [9:0] Bar_Sizey,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_size,
  output logic       ball_lost
);

  typedef enum logic [1:0] {IDLE, MOVE, LOST} state_t;

  localparam logic signed [10:0] STEP11 = 11'(STEP);
  localparam logic signed [10:0] SIZE11 = 11'(SIZE);
  localparam logic signed [11:0] SIZE12 = 12'(SIZE);
  localparam logic signed [11:0] X_MIN12 = 12'(X_MIN);
  localparam logic signed [11:0] X_MAX12 = 12'(X_MAX);
  localparam logic signed [11:0] Y_MIN12 = 12'(Y_MIN);
  localparam logic signed [11:0] Y_MAX12 = 12'(Y_MAX);

  state_t state_q, state_d;
  logic sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic armed_q, armed_d, lost_q, lost_d;
  logic [1:0] fill_q, fill_d;
  logic signed [10:0] px_q, px_d, py_q, py_d, vx_q, vx_d, vy_q, vy_d;
  logic signed [10:0] vx_n, vy_n;

  logic tick, hit;
  logic signed [11:0] px12, py12, barx12, bary12, bsx12, bsy12, dx, adx;

  // Ticks only count once the synchronizer holds a genuine low sample taken after reset.
  assign tick = armed_q & sync2_q & ~sync3_q;

  assign px12   = {px_q[10], px_q};
  assign py12   = {py_q[10], py_q};
  assign barx12 = {2'b00, BarX};
  assign bary12 = {2'b00, BarY};
  assign bsx12  = {2'b00, Bar_Sizex};
  assign bsy12  = {2'b00, Bar_Sizey};
  assign dx     = px12 - barx12;
  assign adx    = dx[11] ? -dx : dx;

  assign hit = (vy_q > 11'sd0) && (py12 + SIZE12 >= bary12 - bsy12) &&
               (py12 <= bary12) && (adx <= bsx12 + SIZE12);

  always_comb begin
    sync1_d = frame_clk;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    armed_d = armed_q | ((fill_q == 2'd2) & ~sync2_q);
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    lost_d  = lost_q;
    vx_n    = vx_q;
    vy_n    = vy_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          px_d = {1'b0, BarX};
          py_d = {1'b0, BarY} - {1'b0, Bar_Sizey} - SIZE11 - 11'sd1;
          vx_d = 11'sd0;
          vy_d = 11'sd0;
          if (launch) begin
            state_d = MOVE;
            vx_d    = STEP11;
            vy_d    = -STEP11;
          end
        end
        MOVE: begin
          if (hit) begin
            vy_n = -STEP11;
            vx_n = dx[11] ? -STEP11 : STEP11;
          end else if (py12 + SIZE12 >= Y_MAX12) begin
            state_d = LOST;
            lost_d  = 1'b1;
          end else begin
            if ((px12 - SIZE12 <= X_MIN12) && (vx_q < 11'sd0)) vx_n = STEP11;
            else if ((px12 + SIZE12 >= X_MAX12) && (vx_q > 11'sd0)) vx_n = -STEP11;
            if ((py12 - SIZE12 <= Y_MIN12) && (vy_q < 11'sd0)) vy_n = STEP11;
          end
          if (state_d == MOVE) begin
            vx_d = vx_n;
            vy_d = vy_n;
            px_d = px_q + vx_n;
            py_d = py_q + vy_n;
          end
        end
        LOST: begin
          if (launch) begin
            state_d = IDLE;
            lost_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      fill_q  <= 2'd0;
      armed_q <= 1'b0;
      px_q    <= 11'sd320;
      py_q    <= 11'sd400;
      vx_q    <= 11'sd0;
      vy_q    <= 11'sd0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      px_q    <= px_d;
      py_q    <= py_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      lost_q  <= lost_d;
    end
  end

  assign BallX     = px_q[9:0];
  assign BallY     = py_q[9:0];
  assign Ball_size = 10'(SIZE);
  assign ball_lost = lost_q;

endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - scoreboard bench for ball_motion
module tb_ball_motion;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic       launch = 1'b0;
  logic [9:0] BarX = 10'd320, BarY = 10'd460, Bar_Sizex = 10'd32, Bar_Sizey = 10'd4;
  logic [9:0] BallX, BallY, Ball_size;
  logic       ball_lost;

  ball_motion dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .launch(launch),
    .BarX(BarX), .BarY(BarY), .Bar_Sizex(Bar_Sizex), .Bar_Sizey(Bar_Sizey),
    .BallX(BallX), .BallY(BallY), .Ball_size(Ball_size), .ball_lost(ball_lost)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0] bx0;
    logic [9:0] by0;
    logic       l0;
    logic [9:0] bx1;
    logic [9:0] by1;
    logic       l1;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int tick_no = 0;
  logic [9:0] cur_x, cur_y;
  logic       cur_l;

  task automatic cmp(input string nm, input int idx, input logic [9:0] ax, input logic [9:0] ay,
                     input logic al, input logic [9:0] ex, input logic [9:0] ey, input logic el);
    n_cmp++;
    if (ax !== ex || ay !== ey || al !== el) begin
      n_bad++;
      $display("FAIL %s tick %0d: got (%0d,%0d,lost=%0b) want (%0d,%0d,lost=%0b)",
               nm, idx, ax, ay, al, ex, ey, el);
    end
  endtask

  // Monitor: the first Clk edge after a frame_clk rise samples it; output must hold at
  // the 2nd edge and take the new value at the 3rd.
  initial begin
    exp_t e;
    forever begin
      @(posedge frame_clk);
      repeat (2) @(posedge Clk);
      #1;
      tick_no++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL no_expectation tick %0d: got (%0d,%0d) want queued entry", tick_no, BallX, BallY);
      end else begin
        e = q.pop_front();
        cmp("hold_before_update", tick_no, BallX, BallY, ball_lost, e.bx0, e.by0, e.l0);
        @(posedge Clk);
        #1;
        cmp("after_update", tick_no, BallX, BallY, ball_lost, e.bx1, e.by1, e.l1);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #2 Reset = 1'b1;
    repeat (4) @(posedge Clk);
    #3;
    cur_x = 10'd320;
    cur_y = 10'd400;
    cur_l = 1'b0;
  endtask

  task automatic tick(input logic [9:0] nx, input logic [9:0] ny, input logic nl);
    exp_t e;
    e = '{cur_x, cur_y, cur_l, nx, ny, nl};
    q.push_back(e);
    cur_x = nx;
    cur_y = ny;
    cur_l = nl;
    frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #3 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #3;
  endtask

  task automatic set_bar(input logic [9:0] x, input logic [9:0] y, input logic [9:0] sx, input logic [9:0] sy);
    BarX = x;
    BarY = y;
    Bar_Sizex = sx;
    Bar_Sizey = sy;
  endtask

  initial begin
    @(posedge Clk);
    #3;
    // A: serve from paddle, launch, first move, launch ignored while moving
    set_bar(10'd320, 10'd460, 10'd32, 10'd4);
    do_reset();
    cmp("reset_state", 0, BallX, BallY, ball_lost, 10'd320, 10'd400, 1'b0);
    n_cmp++;
    if (Ball_size !== 10'd4) begin
      n_bad++;
      $display("FAIL ball_size: got %0d want 4", Ball_size);
    end
    tick(10'd320, 10'd451, 1'b0);
    launch = 1'b1;
    tick(10'd320, 10'd451, 1'b0);
    launch = 1'b0;
    tick(10'd322, 10'd449, 1'b0);
    launch = 1'b1;
    tick(10'd324, 10'd447, 1'b0);
    launch = 1'b0;

    // Reset pulse mid-move while frame_clk is high
    q.push_back('{10'd320, 10'd400, 1'b0, 10'd320, 10'd400, 1'b0});
    frame_clk = 1'b1;
    @(posedge Clk);
    #2 Reset = 1'b0;
    @(posedge Clk);
    #2 Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #3 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #3;
    cur_x = 10'd320;
    cur_y = 10'd400;
    cur_l = 1'b0;
    tick(10'd320, 10'd451, 1'b0);

    // B: right wall at exactly X_MAX
    set_bar(10'd633, 10'd309, 10'd32, 10'd4);
    do_reset();
    tick(10'd633, 10'd300, 1'b0);
    launch = 1'b1;
    tick(10'd633, 10'd300, 1'b0);
    launch = 1'b0;
    tick(10'd635, 10'd298, 1'b0);
    tick(10'd633, 10'd296, 1'b0);
    tick(10'd631, 10'd294, 1'b0);

    // C: top-right corner reflects both axes
    set_bar(10'd627, 10'd21, 10'd32, 10'd4);
    do_reset();
    tick(10'd627, 10'd12, 1'b0);
    launch = 1'b1;
    tick(10'd627, 10'd12, 1'b0);
    launch = 1'b0;
    tick(10'd629, 10'd10, 1'b0);
    tick(10'd631, 10'd8, 1'b0);
    tick(10'd633, 10'd6, 1'b0);
    tick(10'd635, 10'd4, 1'b0);
    tick(10'd633, 10'd6, 1'b0);

    // D: top wall then paddle hits on left and right halves
    set_bar(10'd300, 10'd13, 10'd32, 10'd4);
    do_reset();
    tick(10'd300, 10'd4, 1'b0);
    launch = 1'b1;
    tick(10'd300, 10'd4, 1'b0);
    launch = 1'b0;
    set_bar(10'd320, 10'd14, 10'd32, 10'd4);
    tick(10'd302, 10'd6, 1'b0);
    tick(10'd300, 10'd4, 1'b0);
    tick(10'd298, 10'd6, 1'b0);
    tick(10'd296, 10'd4, 1'b0);
    tick(10'd294, 10'd6, 1'b0);
    set_bar(10'd290, 10'd14, 10'd32, 10'd4);
    tick(10'd296, 10'd4, 1'b0);

    // E: long fall to the bottom, loss, hold, relaunch to IDLE
    set_bar(10'd100, 10'd13, 10'd32, 10'd4);
    do_reset();
    tick(10'd100, 10'd4, 1'b0);
    launch = 1'b1;
    tick(10'd100, 10'd4, 1'b0);
    launch = 1'b0;
    set_bar(10'd1000, 10'd1000, 10'd0, 10'd0);
    for (int k = 1; k <= 236; k++) tick(10'(100 + 2 * k), 10'(4 + 2 * k), 1'b0);
    tick(10'd572, 10'd476, 1'b1);
    tick(10'd572, 10'd476, 1'b1);
    launch = 1'b1;
    repeat (2) @(posedge Clk);
    #3 launch = 1'b0;
    tick(10'd572, 10'd476, 1'b1);
    tick(10'd572, 10'd476, 1'b1);
    launch = 1'b1;
    tick(10'd572, 10'd476, 1'b0);
    launch = 1'b0;
    tick(10'd1000, 10'd995, 1'b0);

    repeat (5) @(posedge Clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expectations: got %0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
